// File: rtl/pwm_speed_ramp.sv
// pwm_speed_ramp
//    Upstream control stage for the PWM generator. Turns a bouncy start/stop
//    button, a target-speed switch bank and an emergency stop into a
//    soft-start / soft-stop sequence. speed_out moves one step at a time
//    toward the target, one step every STEP_CYCLES clocks.
//
// Ports
//    clk           system clock, rising edge
//    rst_n         asynchronous active-low reset
//    ena           tile enable; low forces the same state as estop
//    btn_raw       raw start/stop push-button (async, active high, bouncy)
//    target_speed  requested speed from switches (async)
//    estop         emergency stop (async, active high)
//    speed_out     speed code to the PWM generator
//    pwm_enable    enable to the PWM generator
//    ramping       high while in SLEW or STOPPING
//    at_target     high while in HOLD
//
// State table
//    state    | meaning
//    IDLE     | stopped, speed 0, PWM disabled
//    SLEW     | stepping speed_out toward tgt
//    HOLD     | speed_out == tgt, holding
//    STOPPING | stepping speed_out down to 0, then IDLE
module pwm_speed_ramp #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000,
   parameter int unsigned STEP_CYCLES     = 4096
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       btn_raw,
   input  logic [2:0] target_speed,
   input  logic       estop,
   output logic [2:0] speed_out,
   output logic       pwm_enable,
   output logic       ramping,
   output logic       at_target
);

   localparam int unsigned DEB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned STEP_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [DEB_W-1:0]  DEB_LOAD  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [STEP_W-1:0] STEP_LOAD = STEP_W'(STEP_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SLEW     = 2'd1,
      HOLD     = 2'd2,
      STOPPING = 2'd3
   } state_t;

   state_t state_q, state_nxt;

   logic       btn_s1, btn_s2;
   logic       estop_s1, estop_s2;
   logic [2:0] tgt_s1, tgt_s2, tgt_s3, tgt;

   logic             deb_btn, deb_btn_q;
   logic [DEB_W-1:0] deb_cnt;
   logic             press;

   logic [STEP_W-1:0] step_cnt, step_nxt;
   logic              tick;
   logic [2:0]        speed_q, speed_nxt;
   logic              halt;

   // Synchronizers; tgt only follows the switches once the synchronized
   // value has been seen unchanged on two consecutive cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_s1   <= 1'b0;
         btn_s2   <= 1'b0;
         estop_s1 <= 1'b0;
         estop_s2 <= 1'b0;
         tgt_s1   <= '0;
         tgt_s2   <= '0;
         tgt_s3   <= '0;
         tgt      <= '0;
      end else begin
         btn_s1   <= btn_raw;
         btn_s2   <= btn_s1;
         estop_s1 <= estop;
         estop_s2 <= estop_s1;
         tgt_s1   <= target_speed;
         tgt_s2   <= tgt_s1;
         tgt_s3   <= tgt_s2;
         if (tgt_s2 == tgt_s3) tgt <= tgt_s2;
      end
   end

   // Debounce down-counter holds the number of further disagreeing cycles
   // needed; the level flips on the DEBOUNCE_CYCLES-th consecutive one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_btn   <= 1'b0;
         deb_btn_q <= 1'b0;
         deb_cnt   <= DEB_LOAD;
      end else begin
         deb_btn_q <= deb_btn;
         if (btn_s2 == deb_btn) begin
            deb_cnt <= DEB_LOAD;
         end else if (deb_cnt == '0) begin
            deb_btn <= ~deb_btn;
            deb_cnt <= DEB_LOAD;
         end else begin
            deb_cnt <= deb_cnt - 1'b1;
         end
      end
   end

   assign press = deb_btn & ~deb_btn_q;
   assign halt  = estop_s2 | ~ena;
   assign tick  = ((state_q == SLEW) || (state_q == STOPPING)) && (step_cnt == '0);

   always_comb begin
      state_nxt = state_q;
      speed_nxt = speed_q;
      if (halt) begin
         state_nxt = IDLE;
         speed_nxt = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (press && (tgt != 3'd0)) state_nxt = SLEW;
            end
            SLEW: begin
               if (press) begin
                  state_nxt = STOPPING;
               end else begin
                  if (tick) begin
                     if ((tgt > speed_q) && (speed_q != 3'd7))
                        speed_nxt = speed_q + 3'd1;
                     else if ((tgt < speed_q) && (speed_q != 3'd0))
                        speed_nxt = speed_q - 3'd1;
                  end
                  // Compare against the post-step value so HOLD is entered
                  // on the same edge the final step lands.
                  if (speed_nxt == tgt) state_nxt = HOLD;
               end
            end
            HOLD: begin
               if (press)               state_nxt = STOPPING;
               else if (tgt != speed_q) state_nxt = SLEW;
            end
            STOPPING: begin
               if (press) begin
                  state_nxt = SLEW;
               end else begin
                  if (tick && (speed_q != 3'd0)) speed_nxt = speed_q - 3'd1;
                  if (speed_nxt == 3'd0) state_nxt = IDLE;
               end
            end
            default: begin
               state_nxt = IDLE;
               speed_nxt = '0;
            end
         endcase
      end

      // Step timer reloads on every state entry and outside the ramp states,
      // and wraps after each tick; a tgt change in SLEW does not restart it.
      step_nxt = STEP_LOAD;
      if ((state_nxt == state_q) &&
          ((state_nxt == SLEW) || (state_nxt == STOPPING)) &&
          (step_cnt != '0))
         step_nxt = step_cnt - 1'b1;
   end

   // Outputs are registered from the next state so they always match state_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         speed_q    <= '0;
         step_cnt   <= STEP_LOAD;
         pwm_enable <= 1'b0;
         ramping    <= 1'b0;
         at_target  <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         speed_q    <= speed_nxt;
         step_cnt   <= step_nxt;
         pwm_enable <= (state_nxt != IDLE);
         ramping    <= (state_nxt == SLEW) || (state_nxt == STOPPING);
         at_target  <= (state_nxt == HOLD);
      end
   end

   assign speed_out = speed_q;

endmodule

// File: tb/tb_pwm_speed_ramp.sv
// tb_pwm_speed_ramp
//    Directed bench for pwm_speed_ramp with DEBOUNCE_CYCLES=4, STEP_CYCLES=8.
//    Inputs change and outputs are sampled on the falling clock edge.
module tb_pwm_speed_ramp;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic       btn_raw;
   logic [2:0] target_speed;
   logic       estop;
   logic [2:0] speed_out;
   logic       pwm_enable;
   logic       ramping;
   logic       at_target;

   int checks = 0;
   int errors = 0;

   pwm_speed_ramp #(
      .DEBOUNCE_CYCLES(4),
      .STEP_CYCLES    (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .btn_raw     (btn_raw),
      .target_speed(target_speed),
      .estop       (estop),
      .speed_out   (speed_out),
      .pwm_enable  (pwm_enable),
      .ramping     (ramping),
      .at_target   (at_target)
   );

   always #5 clk = ~clk;

   // Each record: drive inputs, wait wait_cyc falling edges, then compare.
   typedef struct {
      int unsigned wait_cyc;
      logic        btn;
      logic        est;
      logic        en_i;
      logic [2:0]  tgt;
      logic [2:0]  sp;
      logic        pe;
      logic        rp;
      logic        at;
      string       name;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(int unsigned w, logic b, logic e, logic en_i,
                               logic [2:0] t, logic [2:0] sp, logic pe,
                               logic rp, logic at, string nm);
      vec_t v;
      v.wait_cyc = w;
      v.btn      = b;
      v.est      = e;
      v.en_i     = en_i;
      v.tgt      = t;
      v.sp       = sp;
      v.pe       = pe;
      v.rp       = rp;
      v.at       = at;
      v.name     = nm;
      vecs.push_back(v);
   endfunction

   task automatic check(string nm, logic [2:0] sp, logic pe, logic rp, logic at);
      checks++;
      if ({speed_out, pwm_enable, ramping, at_target} !== {sp, pe, rp, at}) begin
         errors++;
         $display("FAIL %s: got speed=%0d en=%b ramp=%b at=%b, want speed=%0d en=%b ramp=%b at=%b",
                  nm, speed_out, pwm_enable, ramping, at_target, sp, pe, rp, at);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // soft start to 5
      add(6, 1,0,1,5, 0,0,0,0, "start_pre_press");
      add(1, 1,0,1,5, 0,1,1,0, "start_slew_entry");
      add(7, 1,0,1,5, 0,1,1,0, "start_pre1");
      add(1, 1,0,1,5, 1,1,1,0, "start_speed1");
      add(7, 1,0,1,5, 1,1,1,0, "start_pre2");
      add(1, 1,0,1,5, 2,1,1,0, "start_speed2");
      add(8, 1,0,1,5, 3,1,1,0, "start_speed3");
      add(8, 1,0,1,5, 4,1,1,0, "start_speed4");
      add(7, 1,0,1,5, 4,1,1,0, "start_pre5");
      add(1, 1,0,1,5, 5,1,0,1, "start_at5");
      add(20,0,0,1,5, 5,1,0,1, "start_hold5");
      // target change in HOLD: down to 2
      add(4, 0,0,1,2, 5,1,0,1, "down_tgt_latency");
      add(1, 0,0,1,2, 5,1,1,0, "down_slew");
      add(7, 0,0,1,2, 5,1,1,0, "down_pre4");
      add(1, 0,0,1,2, 4,1,1,0, "down_4");
      add(8, 0,0,1,2, 3,1,1,0, "down_3");
      add(7, 0,0,1,2, 3,1,1,0, "down_pre2");
      add(1, 0,0,1,2, 2,1,0,1, "down_at2");
      // up to 7 (saturation end)
      add(5, 0,0,1,7, 2,1,1,0, "up_slew");
      add(8, 0,0,1,7, 3,1,1,0, "up_3");
      add(8, 0,0,1,7, 4,1,1,0, "up_4");
      add(16,0,0,1,7, 6,1,1,0, "up_6");
      add(7, 0,0,1,7, 6,1,1,0, "up_pre7");
      add(1, 0,0,1,7, 7,1,0,1, "up_at7");
      add(10,0,0,1,7, 7,1,0,1, "up_hold7");
      // back to 5
      add(13,0,0,1,5, 6,1,1,0, "back5_6");
      add(8, 0,0,1,5, 5,1,0,1, "back5_at5");
      // soft stop, then resume
      add(7, 1,0,1,5, 5,1,1,0, "stop_entry");
      add(8, 0,0,1,5, 4,1,1,0, "stop_4");
      add(8, 0,0,1,5, 3,1,1,0, "stop_3");
      add(7, 1,0,1,5, 3,1,1,0, "resume_entry");
      add(1, 0,0,1,5, 3,1,1,0, "resume_no_dec");
      add(7, 0,0,1,5, 4,1,1,0, "resume_4");
      add(8, 0,0,1,5, 5,1,0,1, "resume_at5");
      // full soft stop to 0
      add(7, 1,0,1,5, 5,1,1,0, "stop2_entry");
      add(8, 0,0,1,5, 4,1,1,0, "stop2_4");
      add(24,0,0,1,5, 1,1,1,0, "stop2_1");
      add(7, 0,0,1,5, 1,1,1,0, "stop2_pre0");
      add(1, 0,0,1,5, 0,0,0,0, "stop2_idle");
      // emergency stop at speed 3
      add(7, 1,0,1,5, 0,1,1,0, "es_slew");
      add(24,0,0,1,5, 3,1,1,0, "es_speed3");
      add(2, 0,1,1,5, 3,1,1,0, "es_sync");
      add(1, 0,1,1,5, 0,0,0,0, "es_stopped");
      add(10,1,1,1,5, 0,0,0,0, "es_press_ignored");
      add(10,0,1,1,5, 0,0,0,0, "es_btn_release");
      add(10,0,0,1,5, 0,0,0,0, "es_release");
      // press with target 0 stays idle
      add(10,0,0,1,0, 0,0,0,0, "t0_settle");
      add(10,1,0,1,0, 0,0,0,0, "t0_press");
      add(10,0,0,1,0, 0,0,0,0, "t0_release");
      add(10,0,0,1,5, 0,0,0,0, "t5_settle");
      // ena low mid-SLEW
      add(7, 1,0,1,5, 0,1,1,0, "ena_slew");
      add(8, 0,0,1,5, 1,1,1,0, "ena_speed1");
      add(1, 0,0,0,5, 0,0,0,0, "ena_low");
      add(5, 0,0,0,5, 0,0,0,0, "ena_low_hold");
      add(5, 0,0,1,5, 0,0,0,0, "ena_back");

      rst_n        = 1'b0;
      ena          = 1'b1;
      btn_raw      = 1'b0;
      estop        = 1'b0;
      target_speed = 3'd5;
      #2;
      check("reset_state", 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("idle_after_reset", 0, 0, 0, 0);

      // bounce: toggle every 2 cycles for 40 cycles
      for (int i = 0; i < 20; i++) begin
         btn_raw = ~btn_raw;
         repeat (2) @(negedge clk);
         if ((i % 5) == 4) check("bounce_idle", 0, 0, 0, 0);
      end
      btn_raw = 1'b0;
      repeat (10) @(negedge clk);
      check("bounce_settle", 0, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         btn_raw      = vecs[i].btn;
         estop        = vecs[i].est;
         ena          = vecs[i].en_i;
         target_speed = vecs[i].tgt;
         repeat (vecs[i].wait_cyc) @(negedge clk);
         check(vecs[i].name, vecs[i].sp, vecs[i].pe, vecs[i].rp, vecs[i].at);
      end

      // asynchronous reset mid-SLEW, between clock edges
      btn_raw = 1'b1;
      repeat (7) @(negedge clk);
      check("rst_slew", 0, 1, 1, 0);
      btn_raw = 1'b0;
      repeat (8) @(negedge clk);
      check("rst_speed1", 1, 1, 1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async", 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_after", 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_speed_ramp.md
Name: pwm_speed_ramp

Overview:
- Upstream control stage for the configurable PWM generator; drives its enable and 3-bit speed inputs.
- Turns a raw start/stop push-button, a target-speed switch bank and an emergency stop into a soft-start / soft-stop sequence.
- Output speed moves one step at a time toward the target, at a programmable rate.

Parameters:
DEBOUNCE_CYCLES, 1000, consecutive stable cycles of the synchronized button needed before its debounced level changes (>=2)
STEP_CYCLES, 4096, clock cycles per one-step change of speed_out (>=2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  tile enable; low forces the same state as estop
btn_raw  input  1  raw start/stop push-button, asynchronous, active high, bouncy
target_speed  input  3  requested speed from switches, asynchronous
estop  input  1  emergency stop, asynchronous, active high
speed_out  output  3  speed code to PWM generator
pwm_enable  output  1  enable to PWM generator
ramping  output  1  high while in SLEW or STOPPING
at_target  output  1  high while in HOLD

Behaviour:
- Reset (rst_n low, asynchronous): speed_out=0, pwm_enable=0, ramping=0, at_target=0. State=IDLE. All synchronizers, debounced level and counters cleared.
- Synchronization: btn_raw and estop each pass through a 2-flop synchronizer.
- target_speed passes through a 2-flop synchronizer. Its internal registered copy (tgt) updates only when the synchronized value is equal on 2 consecutive cycles.
- Debounce: counter clears whenever sync_btn == deb_btn. Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, deb_btn toggles and the counter clears.
- press: a 1-cycle pulse on the cycle after deb_btn rises. Falling edges produce nothing.
- Step timer: cleared on every state entry. Counts 0..STEP_CYCLES-1 while in SLEW or STOPPING. The tick is the cycle at count STEP_CYCLES-1; the timer then wraps to 0.
- All outputs are registered and reflect the state in the same cycle.
- IDLE: speed_out=0, pwm_enable=0.
  - press with tgt!=0 -> SLEW; pwm_enable=1 from this cycle.
  - press with tgt==0 -> stay in IDLE.
- SLEW: pwm_enable=1.
  - On tick, speed_out moves one step toward tgt.
  - When speed_out==tgt (checked every cycle, including right after a step) -> HOLD.
  - press -> STOPPING.
- HOLD: pwm_enable=1, speed_out held.
  - tgt!=speed_out -> SLEW.
  - press -> STOPPING.
  - A HOLD at speed 0 keeps pwm_enable=1.
- STOPPING: pwm_enable=1.
  - On tick, speed_out decrements.
  - When speed_out==0 -> IDLE; pwm_enable falls on the IDLE entry cycle.
  - press -> SLEW (resume toward tgt).
- Same-cycle priority (highest first):
  1. reset
  2. estop/ena-low
  3. press
  4. tick/target compare
- estop_sync=1 or ena=0: on the next clock, state=IDLE, speed_out=0, pwm_enable=0, step timer cleared. press is ignored while either condition holds.
- Debouncing keeps running under estop/ena-low; presses are consumed and discarded.
- speed_out never wraps: it saturates at 0 and 7, and steps are strictly ±1.
- tgt changes mid-SLEW: direction re-evaluates at the next tick; the timer is not restarted.
- Reset mid-ramp returns immediately to reset values.

Test Plan (DEBOUNCE_CYCLES=4, STEP_CYCLES=8):
- Reset/soft start: reset, tgt=5, btn high 20 cycles.
  - pwm_enable rises 2+4+1 cycles after btn edge.
  - speed_out steps 1,2,3,4,5 exactly 8 cycles apart.
  - at_target=1 when 5 is reached.
- Bounce rejection: btn toggling every 2 cycles for 40 cycles -> no press; state stays IDLE. Then stable high -> exactly one press.
- Target change in HOLD: at 5, set tgt=2 -> SLEW, speed 4,3,2 at 8-cycle spacing, HOLD. Then tgt=7 -> 3..7.
- Soft stop and resume:
  - press in HOLD at 5 -> 4,3.
  - press again -> SLEW back up to 5.
  - press -> ramp to 0; pwm_enable drops on the cycle speed_out reaches 0; ramping=0.
- Emergency stop: estop asserted mid-ramp at speed 3 -> two sync cycles +1: speed_out=0, pwm_enable=0. Press while estop high -> ignored.
- ena low and async reset mid-SLEW: both force zeros. rst_n asserted between clocks clears outputs without a clock edge.
